// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes, FSM states, starvation default.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int STARVE_LIMIT_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  // Reserved size 2'b11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: load extract/extend and store lane-merge for sub-word accesses.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [1:0]  lo,
  input  logic [31:0] rd,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd[{lo, 3'b000} +: 8];
  assign half_sel = lo[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    load_data  = rd;
    merge_data = rd;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{byte_sel[7] & ~zext}}, byte_sel};
        merge_data[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{half_sel[15] & ~zext}}, half_sel};
        if (lo[1]) merge_data[31:16] = wdata;
        else       merge_data[15:0]  = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Shares a single-port data memory between the MEM stage and an ext port; sub-word stores take a 2-cycle RMW.
// Ext requests are force-granted after STARVE_LIMIT waiting cycles. DMEM_CTRL_PERF_EN adds stall/grant counters.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [1:0]    core_size,
  input  logic          core_unsigned,
  input  logic [AW-1:0] core_addr,
  input  logic [31:0]   core_wdata,
  output logic [31:0]   core_rdata,
  output logic          core_stall,
  output logic          core_misalign,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [31:0]   ext_wdata,
  output logic          ext_gnt,
  output logic [31:0]   ext_rdata,
  output logic          ext_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
`ifdef DMEM_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_ext_cnt
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t          state, state_d;
  logic [7:0]      wait_cnt;
  logic [31:0]     merge_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     load_data, merge_data;
  logic            force_ext, misalign_raw, rmw_start;
  logic            unused_ext_lo;

  // Ext accesses are always whole words; the low address bits carry no meaning.
  assign unused_ext_lo = ^ext_addr[1:0];

  assign force_ext    = ext_req && (wait_cnt == LIMIT);
  assign misalign_raw = is_misaligned(core_size, core_addr[1:0]);

  dmem_lane_align u_align (
    .size       (core_size),
    .zext       (core_unsigned),
    .lo         (core_addr[1:0]),
    .rd         (mem_rd),
    .wdata      (core_wdata[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    state_d       = state;
    mem_we        = 1'b0;
    mem_a         = '0;
    mem_wd        = '0;
    core_stall    = 1'b0;
    core_misalign = 1'b0;
    core_rdata    = '0;
    ext_gnt       = 1'b0;
    rmw_start     = 1'b0;
    case (state)
      IDLE: begin
        if (force_ext) begin
          ext_gnt    = 1'b1;
          core_stall = core_req;
        end else if (core_req) begin
          mem_a = core_addr;
          if (misalign_raw) begin
            core_misalign = 1'b1;
          end else if (!core_we) begin
            core_rdata = load_data;
          end else if (core_size[1]) begin
            mem_we = 1'b1;
            mem_wd = core_wdata;
          end else begin
            core_stall = 1'b1;
            rmw_start  = 1'b1;
            state_d    = RMW;
          end
        end else if (ext_req) begin
          ext_gnt = 1'b1;
        end
      end
      RMW: begin
        mem_we  = 1'b1;
        mem_a   = addr_q;
        mem_wd  = merge_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ext_gnt) begin
      mem_a  = {ext_addr[AW-1:2], 2'b00};
      mem_we = ext_we;
      mem_wd = ext_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      merge_q    <= '0;
      addr_q     <= '0;
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      state      <= state_d;
      ext_rvalid <= ext_gnt && !ext_we;
      if (ext_gnt && !ext_we) ext_rdata <= mem_rd;
      if (rmw_start) begin
        merge_q <= merge_data;
        addr_q  <= core_addr;
      end
      if (ext_gnt)                            wait_cnt <= '0;
      else if (ext_req && wait_cnt != LIMIT)  wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef DMEM_CTRL_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      perf_stall_cnt <= '0;
      perf_ext_cnt   <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(core_stall);
      perf_ext_cnt   <= perf_ext_cnt + 32'(ext_gnt);
    end
  end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: vector table for single-cycle core accesses, hand sequences for RMW, starvation and reset.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        core_req, core_we, core_unsigned;
  logic [1:0]  core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_stall, core_misalign;
  logic        ext_req, ext_we, ext_gnt, ext_rvalid;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
`ifdef DMEM_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_ext_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];

  // Memory model plus a preload path owned by the bench.
  logic [31:0] mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;

  always #5 CLK = ~CLK;

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge CLK) begin
    if (mem_we)      mem[mem_a[7:2]] <= mem_wd;
    else if (pre_we) mem[pre_idx]    <= pre_dat;
  end

  dmem_ctrl dut (
    .CLK(CLK), .RST(RST),
    .core_req(core_req), .core_we(core_we), .core_size(core_size),
    .core_unsigned(core_unsigned), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall), .core_misalign(core_misalign),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_ext_cnt(perf_ext_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_size = SZ_WORD; core_unsigned = 0;
    core_addr = '0; core_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic core_drive(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] d);
    core_req = 1; core_we = we; core_size = sz; core_unsigned = uns;
    core_addr = a; core_wdata = d;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(posedge CLK); #1;
    pre_we = 1; pre_idx = 6'(idx); pre_dat = d;
    @(posedge CLK); #1;
    pre_we = 0;
  endtask

  // Scoreboard drain: every ext load result must match the value queued at grant time.
  always @(negedge CLK) begin
    if (!RST && ext_rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL ext_rvalid_unexpected: got rdata %h want no pulse", ext_rdata);
      end else begin
        chk("ext_rdata", ext_rdata, sb.pop_front());
      end
    end
  end

  // Ext load held against a continuous core load stream; reports grant cycle and stall cycles.
  task automatic starve_run(input logic [31:0] exp, output int gcyc, output int nstall, output int stall_at);
    gcyc = 0; nstall = 0; stall_at = 0;
    ext_req = 1; ext_we = 0; ext_addr = 32'h14;
    core_drive(0, SZ_WORD, 0, 32'h40, 32'h0);
    for (int c = 1; c <= 20 && gcyc == 0; c++) begin
      @(negedge CLK);
      if (core_stall) begin nstall++; stall_at = c; end
      if (ext_gnt) begin gcyc = c; sb.push_back(exp); end
      @(posedge CLK); #1;
      if (gcyc != 0) ext_req = 0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (core_stall) nstall++;
      @(posedge CLK); #1;
    end
    core_req = 0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        mis;
    logic        stall;
    logic        mwe;
  } vec_t;

  vec_t tv[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int g, ns, sa;
    tv[0]  = '{0, SZ_BYTE, 0, 32'h41, 32'h0, 32'hFFFFFFAA, 0, 0, 0};
    tv[1]  = '{0, SZ_BYTE, 1, 32'h41, 32'h0, 32'h000000AA, 0, 0, 0};
    tv[2]  = '{0, SZ_HALF, 1, 32'h42, 32'h0, 32'h00008899, 0, 0, 0};
    tv[3]  = '{0, SZ_HALF, 0, 32'h42, 32'h0, 32'hFFFF8899, 0, 0, 0};
    tv[4]  = '{0, SZ_HALF, 0, 32'h40, 32'h0, 32'hFFFFAABB, 0, 0, 0};
    tv[5]  = '{0, SZ_WORD, 0, 32'h40, 32'h0, 32'h8899AABB, 0, 0, 0};
    tv[6]  = '{0, SZ_BYTE, 0, 32'h43, 32'h0, 32'hFFFFFF88, 0, 0, 0};
    tv[7]  = '{0, SZ_BYTE, 1, 32'h40, 32'h0, 32'h000000BB, 0, 0, 0};
    tv[8]  = '{0, SZ_HALF, 0, 32'h41, 32'h0, 32'h00000000, 1, 0, 0};
    tv[9]  = '{0, SZ_WORD, 0, 32'h42, 32'h0, 32'h00000000, 1, 0, 0};
    tv[10] = '{1, SZ_WORD, 0, 32'h42, 32'hFFFFFFFF, 32'h0, 1, 0, 0};
    tv[11] = '{0, 2'b11,   0, 32'h40, 32'h0, 32'h8899AABB, 0, 0, 0};
    tv[12] = '{1, SZ_WORD, 0, 32'h48, 32'hCAFEF00D, 32'h0, 0, 0, 1};

    idle_inputs();
    RST = 1;
    preload(16, 32'h8899AABB);
    preload(4,  32'hDEADBEEF);
    preload(5,  32'h0BADF00D);
    preload(8,  32'hA5A5A5A5);
    preload(18, 32'h00000000);

    @(negedge CLK);
    chk("rst_ext_rdata", ext_rdata, 32'h0);
    chk("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'h0);
    RST = 0;
    @(negedge CLK);
    chk("idle_mem_we", {31'b0, mem_we}, 32'h0);
    chk("idle_stall", {31'b0, core_stall}, 32'h0);
    chk("idle_misalign", {31'b0, core_misalign}, 32'h0);
    chk("idle_ext_gnt", {31'b0, ext_gnt}, 32'h0);
    chk("idle_core_rdata", core_rdata, 32'h0);

    for (int i = 0; i < 13; i++) begin
      @(posedge CLK); #1;
      core_drive(tv[i].we, tv[i].sz, tv[i].uns, tv[i].addr, tv[i].wd);
      @(negedge CLK);
      chk($sformatf("v%0d_rdata", i), core_rdata, tv[i].rdata);
      chk($sformatf("v%0d_misalign", i), {31'b0, core_misalign}, {31'b0, tv[i].mis});
      chk($sformatf("v%0d_stall", i), {31'b0, core_stall}, {31'b0, tv[i].stall});
      chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tv[i].mwe});
    end
    @(posedge CLK); #1;
    core_req = 0;
    chk("sw_mis_no_write", mem[16], 32'h8899AABB);
    chk("sw_word_write", mem[18], 32'hCAFEF00D);

    // Byte store read-modify-write
    preload(16, 32'h11223344);
    core_drive(1, SZ_BYTE, 0, 32'h43, 32'hFFFFFF5A);
    @(negedge CLK);
    chk("sb_c0_stall", {31'b0, core_stall}, 32'h1);
    chk("sb_c0_mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge CLK); #1;
    core_req = 0;
    @(negedge CLK);
    chk("sb_c1_mem_we", {31'b0, mem_we}, 32'h1);
    chk("sb_c1_stall", {31'b0, core_stall}, 32'h0);
    chk("sb_c1_mem_a", mem_a, 32'h43);
    chk("sb_c1_mem_wd", mem_wd, 32'h5A223344);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("sb_c2_mem_we", {31'b0, mem_we}, 32'h0);
    chk("sb_result", mem[16], 32'h5A223344);

    // Half store into upper lane
    @(posedge CLK); #1;
    core_drive(1, SZ_HALF, 0, 32'h4A, 32'hAAAA1234);
    @(posedge CLK); #1;
    core_req = 0;
    @(posedge CLK); #1;
    chk("sh_result", mem[18], 32'h1234F00D);

    // Starvation bound, twice to show the wait counter restarts from zero
    for (int r = 0; r < 2; r++) begin
      starve_run(32'h0BADF00D, g, ns, sa);
      chk($sformatf("starve%0d_gnt_cycle", r), 32'(g), 32'd9);
      chk($sformatf("starve%0d_stall_cycles", r), 32'(ns), 32'd1);
      chk($sformatf("starve%0d_stall_at", r), 32'(sa), 32'd9);
    end

    // Ext load with core idle; low address bits ignored
    @(posedge CLK); #1;
    ext_req = 1; ext_we = 0; ext_addr = 32'h13;
    @(negedge CLK);
    chk("extld_gnt", {31'b0, ext_gnt}, 32'h1);
    chk("extld_mem_a", mem_a, 32'h10);
    chk("extld_mem_we", {31'b0, mem_we}, 32'h0);
    if (ext_gnt) sb.push_back(32'hDEADBEEF);
    @(posedge CLK); #1;
    ext_req = 0;
    @(negedge CLK);
    chk("extld_rvalid", {31'b0, ext_rvalid}, 32'h1);
    @(negedge CLK);
    chk("extld_rvalid_drop", {31'b0, ext_rvalid}, 32'h0);

    // Ext store
    @(posedge CLK); #1;
    ext_req = 1; ext_we = 1; ext_addr = 32'h24; ext_wdata = 32'h55AA55AA;
    @(negedge CLK);
    chk("extst_gnt", {31'b0, ext_gnt}, 32'h1);
    chk("extst_mem_we", {31'b0, mem_we}, 32'h1);
    chk("extst_mem_wd", mem_wd, 32'h55AA55AA);
    @(posedge CLK); #1;
    ext_req = 0; ext_we = 0;
    @(negedge CLK);
    chk("extst_no_rvalid", {31'b0, ext_rvalid}, 32'h0);
    chk("extst_result", mem[9], 32'h55AA55AA);

    // Reset landing in the RMW cycle discards the pending write
    @(posedge CLK); #1;
    core_drive(1, SZ_HALF, 0, 32'h22, 32'h0000BEEF);
    @(negedge CLK);
    chk("rstrmw_c0_stall", {31'b0, core_stall}, 32'h1);
    @(posedge CLK); #1;
    RST = 1; core_req = 0;
    @(negedge CLK);
    chk("rstrmw_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rstrmw_stall", {31'b0, core_stall}, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 0;
    chk("rstrmw_mem", mem[8], 32'hA5A5A5A5);
    chk("rstrmw_rvalid", {31'b0, ext_rvalid}, 32'h0);
    @(posedge CLK); #1;
    core_drive(0, SZ_WORD, 0, 32'h20, 32'h0);
    @(negedge CLK);
    chk("rstrmw_idle_rdata", core_rdata, 32'hA5A5A5A5);
    chk("rstrmw_idle_stall", {31'b0, core_stall}, 32'h0);
    @(posedge CLK); #1;
    core_req = 0;

    repeat (3) @(posedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Access controller in front of the single-port word-addressed data memory (async read, sync write on CLK, 64 words). Shares the memory between the pipeline MEM stage (core port) and an external loader/debug port (ext port). Adds sub-word load/store (lb/lh/lbu/lhu/sb/sh) through a two-cycle read-modify-write, misalignment detection, and starvation-bounded arbitration.

Parameters:
STARVE_LIMIT, 8, cycles an ext request may wait before it is force-granted over the core (1..255)
AW, 32, address width on all ports

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  reset, asynchronous, active-high
core_req  input  1  MEM-stage access valid
core_we  input  1  1 = store, 0 = load
core_size  input  2  00 byte, 01 half, 10 word; 11 reserved, treated as word
core_unsigned  input  1  zero-extend loads (lbu/lhu)
core_addr  input  AW  byte address
core_wdata  input  32  store data, right-aligned
core_rdata  output  32  load result, extended; combinational
core_stall  output  1  hold MEM stage this cycle
core_misalign  output  1  misaligned access flag, combinational
ext_req  input  1  ext access request, held until ext_gnt
ext_we  input  1  ext store (always full word)
ext_addr  input  AW  byte address; bits [1:0] ignored
ext_wdata  input  32  ext store data
ext_gnt  output  1  ext access performed this cycle
ext_rdata  output  32  registered ext load data
ext_rvalid  output  1  one-cycle pulse, cycle after a granted ext load
mem_we  output  1  to memory write enable
mem_a  output  AW  to memory address
mem_wd  output  32  to memory write data
mem_rd  input  32  from memory read data (combinational)

Behaviour:
- Reset (asynchronous, active-high, one clock CLK): state=IDLE, wait_cnt=0, merge_q=0, addr_q=0, ext_rdata=0, ext_rvalid=0. Combinational outputs with no request: mem_we=0, core_stall=0, core_misalign=0, ext_gnt=0, core_rdata=0.
- States: IDLE, RMW.
- IDLE grant order: force-ext if wait_cnt==STARVE_LIMIT and ext_req; else core if core_req; else ext if ext_req.
- Core load: mem_a=core_addr; core_rdata = selected byte/half of mem_rd by addr[1:0], sign- or zero-extended; zero latency, no stall.
- Core word store: mem_we=1, mem_wd=core_wdata same cycle; no stall.
- Core byte/half store: cycle 0 (IDLE) reads mem_rd, merges lane into merge_q, latches addr_q, core_stall=1, go RMW. Cycle 1 (RMW): mem_we=1, mem_a=addr_q, mem_wd=merge_q, core_stall=0, return IDLE.
- Misaligned (half with addr[0]=1, word with addr[1:0]!=0): core_misalign=1, no write, core_rdata=0, no stall.
- Ext grant: ext_gnt=1, mem_a={ext_addr[AW-1:2],2'b00}; store writes same cycle; load captures mem_rd into ext_rdata, ext_rvalid=1 next cycle.
- Force-ext cycle with core_req=1: core_stall=1, core access retried next cycle.
- RMW state: ext never granted; core_req ignored (stage is advancing).
- wait_cnt: increments (saturating at STARVE_LIMIT) each cycle ext_req=1 and ext_gnt=0; cleared on ext_gnt.
- RST asserted during RMW: pending write discarded; memory unchanged.

Optional Feature:
DMEM_CTRL_PERF_EN: adds outputs perf_stall_cnt[31:0] (cycles core_stall=1) and perf_ext_cnt[31:0] (ext grants); both wrap, reset to 0. Without it: ports and counters absent, behaviour otherwise identical.

Decomposition:
- dmem_ctrl_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encodings, STARVE_LIMIT default.
- Sub-module dmem_lane_align (combinational): load extract/extend and store lane-merge, given size, unsigned, addr[1:0].

Test Plan:
- Word 0x40 = 0x8899AABB; core lb addr 0x41 -> core_rdata 0xFFFFFFAA; lbu -> 0x000000AA; lhu addr 0x42 -> 0x00008899; core_stall=0.
- sb 0x5A to 0x43 on 0x11223344 -> stall one cycle, mem_we in cycle 2 only, word becomes 0x5A223344.
- lh addr 0x41 -> core_misalign=1, core_rdata=0; sw addr 0x42 -> no write, memory unchanged.
- ext_req held, core_req continuous, STARVE_LIMIT=8 -> ext_gnt on 9th cycle, core_stall=1 that cycle only, wait_cnt returns to 0.
- ext load addr 0x10 (word 0xDEADBEEF) while core idle -> ext_gnt same cycle, ext_rvalid pulse next cycle, ext_rdata=0xDEADBEEF.
- sh to 0x20 with RST asserted in RMW cycle -> no write, state IDLE, ext_rvalid=0.
